// File: rtl/writeback_stage.sv
// MEM/WB pipeline latch and write-back logic for the 5-stage MIPS core.
// The latch captures the memory-stage slot on the rising edge. The outputs are
// decoded from the latch alone and feed the register file write port, which
// commits on the following falling edge. A saturating retired-instruction
// counter and a sticky halt flag are kept for the debug unit.
module writeback_stage #(
  parameter int LEN     = 32,
  parameter int NB_ADDR = 5,
  parameter int NB_CNT  = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_enable,
  input  logic               i_flush,
  input  logic               i_valid,
  input  logic               i_RegWrite,
  input  logic               i_MemtoReg,
  input  logic [2:0]         i_load_type,
  input  logic [1:0]         i_byte_offset,
  input  logic [LEN-1:0]     i_mem_data,
  input  logic [LEN-1:0]     i_alu_result,
  input  logic [NB_ADDR-1:0] i_write_register,
  input  logic               i_halt,
  output logic               o_RegWrite,
  output logic [NB_ADDR-1:0] o_write_register,
  output logic [LEN-1:0]     o_write_data,
  output logic [NB_CNT-1:0]  o_retired,
  output logic               o_halted
);

  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LW  = 3'b010;
  localparam logic [2:0] LT_LBU = 3'b100;
  localparam logic [2:0] LT_LHU = 3'b101;

  localparam logic [NB_CNT-1:0] CNT_MAX = {NB_CNT{1'b1}};
  localparam logic [NB_CNT-1:0] CNT_ONE = {{(NB_CNT-1){1'b0}}, 1'b1};

  // Latch fields (current and next)
  logic               valid_q,          valid_d;
  logic               regwrite_q,       regwrite_d;
  logic               memtoreg_q,       memtoreg_d;
  logic [2:0]         load_type_q,      load_type_d;
  logic [1:0]         byte_offset_q,    byte_offset_d;
  logic [LEN-1:0]     mem_data_q,       mem_data_d;
  logic [LEN-1:0]     alu_result_q,     alu_result_d;
  logic [NB_ADDR-1:0] write_register_q, write_register_d;
  logic               halt_q,           halt_d;

  // Debug state
  logic [NB_CNT-1:0]  retired_q,        retired_d;
  logic               halted_q,         halted_d;

  // Aligns the addressed byte/halfword of the raw memory word and extends it.
  // Halfword selection only looks at offset[1]; unaligned halves are not split.
  function automatic logic [LEN-1:0] load_extract(
    input logic [2:0]     load_type,
    input logic [1:0]     offset,
    input logic [LEN-1:0] data
  );
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [LEN-1:0] result;
    byte_sel = data[{offset, 3'b000} +: 8];
    half_sel = data[{offset[1], 4'b0000} +: 16];
    case (load_type)
      LT_LB:   result = {{(LEN-8){byte_sel[7]}}, byte_sel};
      LT_LH:   result = {{(LEN-16){half_sel[15]}}, half_sel};
      LT_LBU:  result = {{(LEN-8){1'b0}}, byte_sel};
      LT_LHU:  result = {{(LEN-16){1'b0}}, half_sel};
      LT_LW:   result = data;
      default: result = data;
    endcase
    return result;
  endfunction

  // Next-state selection: hold on stall, bubble when halted or flushed, else capture
  always_comb begin
    valid_d          = valid_q;
    regwrite_d       = regwrite_q;
    memtoreg_d       = memtoreg_q;
    load_type_d      = load_type_q;
    byte_offset_d    = byte_offset_q;
    mem_data_d       = mem_data_q;
    alu_result_d     = alu_result_q;
    write_register_d = write_register_q;
    halt_d           = halt_q;
    retired_d        = retired_q;
    halted_d         = halted_q;

    if (!i_enable) begin
      // stall: everything holds, a concurrent flush is dropped
      valid_d = valid_q;
    end else if (halted_q || i_flush) begin
      valid_d          = 1'b0;
      regwrite_d       = 1'b0;
      memtoreg_d       = 1'b0;
      load_type_d      = 3'b000;
      byte_offset_d    = 2'b00;
      mem_data_d       = {LEN{1'b0}};
      alu_result_d     = {LEN{1'b0}};
      write_register_d = {NB_ADDR{1'b0}};
      halt_d           = 1'b0;
    end else begin
      valid_d          = i_valid;
      regwrite_d       = i_RegWrite;
      memtoreg_d       = i_MemtoReg;
      load_type_d      = i_load_type;
      byte_offset_d    = i_byte_offset;
      mem_data_d       = i_mem_data;
      alu_result_d     = i_alu_result;
      write_register_d = i_write_register;
      halt_d           = i_halt;
      if (i_valid) begin
        if (retired_q != CNT_MAX) begin
          retired_d = retired_q + CNT_ONE;
        end else begin
          retired_d = retired_q;
        end
        if (i_halt) begin
          halted_d = 1'b1;
        end else begin
          halted_d = halted_q;
        end
      end else begin
        retired_d = retired_q;
      end
    end
  end

  // State registers with synchronous reset; a slot held at reset is discarded
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q          <= 1'b0;
      regwrite_q       <= 1'b0;
      memtoreg_q       <= 1'b0;
      load_type_q      <= 3'b000;
      byte_offset_q    <= 2'b00;
      mem_data_q       <= {LEN{1'b0}};
      alu_result_q     <= {LEN{1'b0}};
      write_register_q <= {NB_ADDR{1'b0}};
      halt_q           <= 1'b0;
      retired_q        <= {NB_CNT{1'b0}};
      halted_q         <= 1'b0;
    end else begin
      valid_q          <= valid_d;
      regwrite_q       <= regwrite_d;
      memtoreg_q       <= memtoreg_d;
      load_type_q      <= load_type_d;
      byte_offset_q    <= byte_offset_d;
      mem_data_q       <= mem_data_d;
      alu_result_q     <= alu_result_d;
      write_register_q <= write_register_d;
      halt_q           <= halt_d;
      retired_q        <= retired_d;
      halted_q         <= halted_d;
    end
  end

  // Write-port decode from the latch only; writes to $0 are suppressed
  always_comb begin
    o_RegWrite       = valid_q & regwrite_q & (write_register_q != {NB_ADDR{1'b0}});
    o_write_register = write_register_q;
    if (memtoreg_q) begin
      o_write_data = load_extract(load_type_q, byte_offset_q, mem_data_q);
    end else begin
      o_write_data = alu_result_q;
    end
    o_retired = retired_q;
    // a latched valid HALT always coincides with halted_q; OR-ing it in lets the
    // debug view see the halting slot itself without depending on that pairing
    o_halted  = halted_q | (valid_q & halt_q);
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage. A behavioural model tracks what the
// register-file write port, retire count and halt flag must show; a compare
// process checks both DUT instances against it on every falling edge, and
// literal expectations from hand calculation pin the model.
module tb_writeback_stage;

  logic        clk;
  logic        rst, enable, flush, valid, rw, mt, halt;
  logic [2:0]  lt;
  logic [1:0]  off;
  logic [31:0] mem, alu;
  logic [4:0]  wr;

  logic        d_we,  s_we;
  logic [4:0]  d_reg, s_reg;
  logic [31:0] d_data, s_data;
  logic [31:0] d_ret;
  logic [3:0]  s_ret;
  logic        d_halted, s_halted;

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;

  // model state
  bit          m_we;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  longint      m_cnt;
  bit          m_halted;

  writeback_stage #(.LEN(32), .NB_ADDR(5), .NB_CNT(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_flush(flush), .i_valid(valid),
    .i_RegWrite(rw), .i_MemtoReg(mt), .i_load_type(lt), .i_byte_offset(off),
    .i_mem_data(mem), .i_alu_result(alu), .i_write_register(wr), .i_halt(halt),
    .o_RegWrite(d_we), .o_write_register(d_reg), .o_write_data(d_data),
    .o_retired(d_ret), .o_halted(d_halted)
  );

  writeback_stage #(.LEN(32), .NB_ADDR(5), .NB_CNT(4)) dut_sat (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_flush(flush), .i_valid(valid),
    .i_RegWrite(rw), .i_MemtoReg(mt), .i_load_type(lt), .i_byte_offset(off),
    .i_mem_data(mem), .i_alu_result(alu), .i_write_register(wr), .i_halt(halt),
    .o_RegWrite(s_we), .o_write_register(s_reg), .o_write_data(s_data),
    .o_retired(s_ret), .o_halted(s_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // value the register file must receive, by plain shift/mask arithmetic
  function automatic logic [31:0] wb_value(bit memtoreg, logic [2:0] t, logic [1:0] o,
                                           logic [31:0] md, logic [31:0] ad);
    logic [31:0] b, h;
    if (!memtoreg) return ad;
    b = (md >> (8 * int'(o))) & 32'h0000_00FF;
    h = (md >> ((o >= 2'd2) ? 16 : 0)) & 32'h0000_FFFF;
    case (t)
      3'b000:  return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
      3'b001:  return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return md;
    endcase
  endfunction

  function automatic longint sat(longint n, longint maxv);
    return (n > maxv) ? maxv : n;
  endfunction

  // model: what the write port and debug outputs become after each rising edge
  always @(posedge clk) begin
    if (rst) begin
      m_we = 1'b0; m_reg = 5'd0; m_data = 32'd0; m_cnt = 0; m_halted = 1'b0;
    end else if (!enable) begin
      m_cnt = m_cnt;
    end else if (m_halted || flush) begin
      m_we = 1'b0; m_reg = 5'd0; m_data = 32'd0;
    end else begin
      m_we   = valid && rw && (wr != 5'd0);
      m_reg  = wr;
      m_data = wb_value(mt, lt, off, mem, alu);
      if (valid) begin
        m_cnt = m_cnt + 1;
        if (halt) m_halted = 1'b1;
      end
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // compare process: both instances against the model every falling edge
  always @(negedge clk) begin
    if (check_en) begin
      chk("we",       64'(d_we),     64'(m_we));
      chk("reg",      64'(d_reg),    64'(m_reg));
      chk("data",     64'(d_data),   64'(m_data));
      chk("retired",  64'(d_ret),    64'(sat(m_cnt, 64'hFFFF_FFFF)));
      chk("halted",   64'(d_halted), 64'(m_halted));
      chk("sat_we",   64'(s_we),     64'(m_we));
      chk("sat_data", 64'(s_data),   64'(m_data));
      chk("sat_ret",  64'(s_ret),    64'(sat(m_cnt, 64'd15)));
    end
  end

  task automatic drive(bit r, bit en, bit fl, bit v, bit w, bit m, logic [2:0] t,
                       logic [1:0] o, logic [31:0] md, logic [31:0] ad,
                       logic [4:0] wreg, bit h);
    rst = r; enable = en; flush = fl; valid = v; rw = w; mt = m;
    lt = t; off = o; mem = md; alu = ad; wr = wreg; halt = h;
    @(negedge clk);
  endtask

  task automatic ins(bit w, bit m, logic [2:0] t, logic [1:0] o, logic [31:0] md,
                     logic [31:0] ad, logic [4:0] wreg);
    drive(1'b0, 1'b1, 1'b0, 1'b1, w, m, t, o, md, ad, wreg, 1'b0);
  endtask

  // literal expectation checked against DUT and against the model
  task automatic lit_data(string name, logic [31:0] exp);
    chk({name, "_dut"},   64'(d_data), 64'(exp));
    chk({name, "_model"}, 64'(m_data), 64'(exp));
  endtask

  task automatic lit_state(string name, bit we, longint ret, bit hlt);
    chk({name, "_we"},     64'(d_we),     64'(we));
    chk({name, "_ret"},    64'(d_ret),    64'(ret));
    chk({name, "_halted"}, 64'(d_halted), 64'(hlt));
    chk({name, "_mret"},   64'(sat(m_cnt, 64'hFFFF_FFFF)), 64'(ret));
  endtask

  localparam logic [31:0] MW = 32'h80FF_7F81;

  initial begin
    drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          3'($urandom), 2'($urandom), $urandom, $urandom, 5'($urandom), 1'($urandom));
    chk("rst_we",   64'(d_we),   64'd0);
    chk("rst_reg",  64'(d_reg),  64'd0);
    chk("rst_data", 64'(d_data), 64'd0);
    lit_state("rst", 1'b0, 0, 1'b0);
    check_en = 1'b1;
    drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          3'($urandom), 2'($urandom), $urandom, $urandom, 5'($urandom), 1'($urandom));

    // ALU result
    ins(1'b1, 1'b0, 3'b000, 2'd0, 32'hDEAD_BEEF, 32'h0000_1234, 5'd7);
    lit_data("alu", 32'h0000_1234);
    chk("alu_reg", 64'(d_reg), 64'd7);
    lit_state("alu", 1'b1, 1, 1'b0);

    // load extraction
    ins(1'b1, 1'b1, 3'b000, 2'd0, MW, 32'h1, 5'd3); lit_data("lb0",  32'hFFFF_FF81);
    ins(1'b1, 1'b1, 3'b100, 2'd0, MW, 32'h1, 5'd3); lit_data("lbu0", 32'h0000_0081);
    ins(1'b1, 1'b1, 3'b000, 2'd1, MW, 32'h1, 5'd3); lit_data("lb1",  32'h0000_007F);
    ins(1'b1, 1'b1, 3'b001, 2'd2, MW, 32'h1, 5'd3); lit_data("lh2",  32'hFFFF_80FF);
    ins(1'b1, 1'b1, 3'b101, 2'd2, MW, 32'h1, 5'd3); lit_data("lhu2", 32'h0000_80FF);
    ins(1'b1, 1'b1, 3'b010, 2'd1, MW, 32'h1, 5'd3); lit_data("lw",   32'h80FF_7F81);
    ins(1'b1, 1'b1, 3'b111, 2'd3, MW, 32'h1, 5'd3); lit_data("lt7",  32'h80FF_7F81);
    ins(1'b1, 1'b1, 3'b000, 2'd3, MW, 32'h1, 5'd3); lit_data("lb3",  32'hFFFF_FF80);
    ins(1'b1, 1'b1, 3'b001, 2'd1, MW, 32'h1, 5'd3); lit_data("lh1",  32'h0000_7F81);
    lit_state("loads", 1'b1, 10, 1'b0);

    // sweep of every type/offset against the model
    for (int t = 0; t < 8; t++)
      for (int o = 0; o < 4; o++)
        ins(1'b1, 1'b1, 3'(t), 2'(o), 32'h7F80_01FE ^ (32'(t) << 8), 32'h0, 5'(t + 1));

    // stall for 3 cycles with changing inputs (one with flush)
    ins(1'b1, 1'b0, 3'b000, 2'd0, 32'h0, 32'h0000_5A5A, 5'd9);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b0, 2'd0, 32'h0, 32'h1111_1111, 5'd1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b0, 2'd0, 32'h0, 32'h2222_2222, 5'd2, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'b0, 2'd0, 32'h0, 32'h3333_3333, 5'd4, 1'b1);
    lit_data("stall", 32'h0000_5A5A);
    chk("stall_reg", 64'(d_reg), 64'd9);
    lit_state("stall", 1'b1, 43, 1'b0);

    // flush with valid instruction: bubble, not counted
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b0, 2'd0, 32'h0, 32'h4444_4444, 5'd4, 1'b0);
    lit_state("flush", 1'b0, 43, 1'b0);

    // write to $0: suppressed but retired
    ins(1'b1, 1'b0, 3'b000, 2'd0, 32'h0, 32'h0000_0055, 5'd0);
    lit_state("r0", 1'b0, 44, 1'b0);

    // invalid slot: no write, no count
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b0, 2'd0, 32'h0, 32'h66, 5'd6, 1'b0);
    lit_state("inval", 1'b0, 44, 1'b0);

    // reset mid-operation discards the held slot
    ins(1'b1, 1'b0, 3'b000, 2'd0, 32'h0, 32'h77, 5'd8);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b0, 2'd0, 32'h0, 32'h88, 5'd8, 1'b0);
    lit_state("rst2", 1'b0, 0, 1'b0);

    // halt sequence
    for (int i = 0; i < 3; i++) ins(1'b1, 1'b0, 3'b0, 2'd0, 32'h0, 32'(i + 100), 5'(i + 10));
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b0, 2'd0, 32'h0, 32'h0, 5'd0, 1'b1);
    lit_state("halt", 1'b0, 4, 1'b1);
    for (int i = 0; i < 2; i++) ins(1'b1, 1'b0, 3'b0, 2'd0, 32'h0, 32'h99, 5'd9);
    lit_state("posthalt", 1'b0, 4, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b0, 2'd0, 32'h0, 32'h0, 5'd0, 1'b0);
    lit_state("haltrst", 1'b0, 0, 1'b0);

    // saturation of the 4-bit counter
    for (int i = 0; i < 20; i++) ins(1'b1, 1'b0, 3'b0, 2'd0, 32'h0, 32'(i), 5'd1);
    chk("sat4", 64'(s_ret), 64'd15);
    chk("sat4_model", 64'(sat(m_cnt, 64'd15)), 64'd15);
    lit_state("sat32", 1'b1, 20, 1'b0);

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
